strip_mem_arbiter: RTL and testbench

- Shares one synchronous-read frame-buffer RAM port between NUM_PORTS strip drivers.
- Each driver keeps its existing handshake: hold mem_req high with mem_addr stable, latch mem_data in the cycle mem_rdy is high, then drop mem_req.
- The arbiter grants one request at a time in round-robin order, issues a single RAM read, and returns the byte to the granted port with a one-cycle rdy pulse.
- It sits between the strip_driver instances and the frame-buffer RAM.

---
 rtl/strip_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_strip_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read frame-buffer RAM port
// between NUM_PORTS strip drivers; one RAM read per grant, rdy pulse back.
module strip_mem_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_LATENCY   = 1,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               req,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr,
  output logic [NUM_PORTS-1:0]               rdy,
  output logic [DATA_WIDTH-1:0]              data,
  output logic                               ram_en,
  output logic [ADDRESS_WIDTH-1:0]           ram_addr,
  input  logic [DATA_WIDTH-1:0]              ram_data,
  output logic                               busy,
  output logic [GW-1:0]                      grant_idx
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            ptr_q, ptr_d;
  logic [GW-1:0]            gnt_q, gnt_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]     rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                     ram_en_q, ram_en_d;
  logic                     busy_q, busy_d;

  logic [GW-1:0] sel, cand;
  logic          sel_vld;
  int            idx;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = GW'(idx);
      if (!sel_vld && req[cand]) begin
        sel_vld = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    ram_addr_d = ram_addr_q;
    rdy_d      = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt_d      = sel;
          ram_addr_d = addr[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d        = ram_data;
          rdy_d[gnt_q]  = 1'b1;
          state_d       = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        ptr_d   = (gnt_q == GW'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs follow the next state so they are registered with it.
    ram_en_d = (state_d == ISSUE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      rdy_q      <= '0;
      data_q     <= '0;
      ram_addr_q <= '0;
      ram_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
      ram_addr_q <= ram_addr_d;
      ram_en_q   <= ram_en_d;
      busy_q     <= busy_d;
    end
  end

  assign rdy       = rdy_q;
  assign data      = data_q;
  assign ram_en    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign busy      = busy_q;
  assign grant_idx = gnt_q;
endmodule

// File: tb/tb_strip_mem_arbiter.sv
// Bench for strip_mem_arbiter: two instances (RAM latency 1 and 3) against a
// cycle-offset model of the arbitration rules, plus hand-computed checks.
module tb_strip_mem_arbiter;
  localparam int N = 4, AW = 13, DW = 8;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req0, req1, pend0, pend1, cont;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    rdy0, rdy1;
  logic [DW-1:0]   data0, data1, ram_data0, ram_data1;
  logic            ram_en0, ram_en1, busy0, busy1;
  logic [AW-1:0]   ram_addr0, ram_addr1;
  logic [1:0]      gi0, gi1;

  strip_mem_arbiter #(.NUM_PORTS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr), .rdy(rdy0), .data(data0), .ram_en(ram_en0),
    .ram_addr(ram_addr0), .ram_data(ram_data0), .busy(busy0), .grant_idx(gi0));
  strip_mem_arbiter #(.NUM_PORTS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr), .rdy(rdy1), .data(data1), .ram_en(ram_en1),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .busy(busy1), .grant_idx(gi1));

  // Frame-buffer RAMs; junk is returned for cycles without a read.
  logic [7:0] mem [8192];
  logic [7:0] p0 = 8'h00;
  logic [7:0] p3 [3] = '{8'h00, 8'h00, 8'h00};
  always @(posedge clk) begin
    p0    <= ram_en0 ? mem[ram_addr0] : 8'hEE;
    p3[0] <= ram_en1 ? mem[ram_addr1] : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram_data0 = p0;
  assign ram_data1 = p3[2];

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: a grant in cycle T gives ram_en at T+1, rdy/data at T+2+L,
  // busy over T+1..T+2+L, and next arbitration at T+3+L.
  bit         m_act [2];
  int         m_t [2], m_g [2], m_ptr [2];
  logic [AW-1:0] m_addr [2];
  logic       e_busy [2], e_en [2];
  logic [3:0] e_rdy [2];
  logic [1:0] e_gi [2];
  logic [AW-1:0] e_ra [2];
  logic [7:0] e_data [2];
  int mc = 0, mk_l, mk_k, mk_idx;
  logic [3:0] mk_rq;
  bit mk_found, mstart = 0;

  always @(negedge clk) begin
    if (mstart) begin
      chk("cycle_lat1", {busy0, ram_en0, rdy0, gi0, ram_addr0, data0},
          {e_busy[0], e_en[0], e_rdy[0], e_gi[0], e_ra[0], e_data[0]});
      chk("cycle_lat3", {busy1, ram_en1, rdy1, gi1, ram_addr1, data1},
          {e_busy[1], e_en[1], e_rdy[1], e_gi[1], e_ra[1], e_data[1]});
    end
    for (int k = 0; k < 2; k++) begin
      mk_l  = (k == 0) ? 1 : 3;
      mk_rq = (k == 0) ? req0 : req1;
      if (!rst) begin
        m_act[k] = 0; m_ptr[k] = 0; m_g[k] = 0;
        e_busy[k] = 0; e_en[k] = 0; e_rdy[k] = 0; e_gi[k] = 0; e_ra[k] = 0; e_data[k] = 0;
      end else begin
        if (m_act[k] && mc - m_t[k] == mk_l + 2) begin
          m_act[k] = 0;
          m_ptr[k] = (m_g[k] + 1) % N;
        end else if (!m_act[k] && mk_rq != 0) begin
          mk_found = 0;
          for (int j = 0; j < N; j++) begin
            mk_idx = (m_ptr[k] + j) % N;
            if (!mk_found && mk_rq[mk_idx]) begin mk_found = 1; m_g[k] = mk_idx; end
          end
          m_act[k]  = 1;
          m_t[k]    = mc;
          m_addr[k] = addr[m_g[k]*AW +: AW];
          e_gi[k]   = 2'(m_g[k]);
          e_ra[k]   = m_addr[k];
        end
        mk_k      = mc + 1 - m_t[k];
        e_busy[k] = m_act[k] && mk_k >= 1 && mk_k <= mk_l + 2;
        e_en[k]   = m_act[k] && mk_k == 1;
        e_rdy[k]  = (m_act[k] && mk_k == mk_l + 2) ? 4'(1 << m_g[k]) : 4'b0;
        if (e_rdy[k] != 0) e_data[k] = mem[m_addr[k]];
      end
    end
    mc++;
    mstart = 1;
  end

  // Driver side: hold req until rdy, optionally re-request one cycle later.
  int tcyc = 0, ecnt0 = 0, ecnt1 = 0, tq = 0;
  int order0 [$], order1 [$], rt0 [$], rt1 [$];

  task automatic step();
    @(posedge clk); #1;
    tcyc++;
    if (ram_en0) ecnt0++;
    if (ram_en1) ecnt1++;
    for (int p = 0; p < N; p++) begin
      if (rdy0[p]) begin
        order0.push_back(p); rt0.push_back(tcyc);
        req0[p] = 1'b0; if (cont[p]) pend0[p] = 1'b1;
      end else if (pend0[p]) begin
        req0[p] = 1'b1; pend0[p] = 1'b0;
      end
      if (rdy1[p]) begin
        order1.push_back(p); rt1.push_back(tcyc);
        req1[p] = 1'b0; if (cont[p]) pend1[p] = 1'b1;
      end else if (pend1[p]) begin
        req1[p] = 1'b1; pend1[p] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1 || req0 != 0 || req1 != 0 || pend0 != 0 || pend1 != 0) && n < 300) begin
      step(); n++;
    end
    chk("idle_reached", 32'(n < 300), 32'd1);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0; req0 = '0; req1 = '0; pend0 = '0; pend1 = '0; cont = '0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic clear_logs();
    order0.delete(); order1.delete(); rt0.delete(); rt1.delete();
  endtask

  function automatic int at(input int q [$], input int i);
    return (i < q.size()) ? q[i] : 99;
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 37 + 11) ^ 8'(i >> 8);
    mem[5] = 8'hA7; mem[13'h1FFF] = 8'h5C;
    addr = '0; req0 = '0; req1 = '0; pend0 = '0; pend1 = '0; cont = '0; rst = 1'b0;
    repeat (3) step();
    chk("reset_outs_lat1", {busy0, ram_en0, rdy0, gi0, ram_addr0, data0}, 32'd0);
    chk("reset_outs_lat3", {busy1, ram_en1, rdy1, gi1, ram_addr1, data1}, 32'd0);

    // Single request, arbitration in the first cycle out of reset
    rst = 1'b1;
    addr[1*AW +: AW] = 13'h005; req0 = 4'b0010; req1 = 4'b0010;
    step();
    chk("single_en", 32'(ram_en0), 32'd1);
    chk("single_addr", 32'(ram_addr0), 32'h5);
    step(); step();
    chk("single_rdy", 32'(rdy0), 32'h2);
    chk("single_data", 32'(data0), 32'hA7);
    step();
    chk("single_busy_low", 32'(busy0), 32'd0);
    step();
    chk("single_rdy_lat3", 32'(rdy1), 32'h2);
    chk("single_data_lat3", 32'(data1), 32'hA7);
    wait_idle();

    // All four ports continuously after reset
    do_reset(); clear_logs();
    for (int p = 0; p < N; p++) addr[p*AW +: AW] = 13'(16 * (p + 1));
    cont = 4'b1111; req0 = 4'b1111; req1 = 4'b1111;
    repeat (20) step();
    cont = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      chk("rr_order_lat1", 32'(at(order0, i)), 32'(i % 4));
      chk("rr_order_lat3", 32'(at(order1, i)), 32'(i % 4));
    end
    chk("rr_spacing_lat1", 32'(at(rt0, 1) - at(rt0, 0)), 32'd4);
    chk("rr_spacing_lat3", 32'(at(rt1, 1) - at(rt1, 0)), 32'd6);

    // Ports 3 and 1 together with the pointer at 2
    do_reset();
    req0 = 4'b0010; req1 = 4'b0010;
    wait_idle(); clear_logs();
    req0 = 4'b1010; req1 = 4'b1010;
    wait_idle();
    chk("ptr2_first", 32'(at(order0, 0)), 32'd3);
    chk("ptr2_second", 32'(at(order0, 1)), 32'd1);
    chk("ptr2_first_lat3", 32'(at(order1, 0)), 32'd3);

    // Top address; address changes after grant must not matter
    clear_logs(); ecnt0 = 0; ecnt1 = 0;
    addr[0 +: AW] = 13'h1FFF; tq = tcyc; req0 = 4'b0001; req1 = 4'b0001;
    step();
    addr[0 +: AW] = 13'h0001;
    wait_idle();
    chk("toprow_rdy_offset_lat3", 32'(at(rt1, 0) - tq), 32'd5);
    chk("toprow_rdy_offset_lat1", 32'(at(rt0, 0) - tq), 32'd3);
    chk("toprow_en_cycles_lat3", 32'(ecnt1), 32'd1);
    chk("toprow_data_lat3", 32'(data1), 32'h5C);
    chk("toprow_data_lat1", 32'(data0), 32'h5C);

    // Reset while waiting on RAM; pending ports 2 and 3 afterwards
    clear_logs();
    addr[2*AW +: AW] = 13'h222; addr[3*AW +: AW] = 13'h333;
    req0 = 4'b0001; req1 = 4'b0001;
    step(); step();
    rst = 1'b0; req0 = 4'b1100; req1 = 4'b1100;
    step();
    chk("midrst_rdy", 32'({rdy0, rdy1}), 32'd0);
    chk("midrst_busy", 32'({busy0, busy1}), 32'd0);
    chk("midrst_en", 32'({ram_en0, ram_en1}), 32'd0);
    rst = 1'b1;
    step();
    chk("midrst_regrant_idx", 32'(gi0), 32'd2);
    chk("midrst_regrant_en", 32'(ram_en0), 32'd1);
    wait_idle();
    chk("midrst_order0", 32'(at(order0, 0)), 32'd2);
    chk("midrst_order1", 32'(at(order0, 1)), 32'd3);
    chk("midrst_count", 32'(order0.size()), 32'd2);

    // Request dropped right after grant still gets its rdy
    clear_logs();
    addr[3*AW +: AW] = 13'h0AB; req0 = 4'b1000; req1 = 4'b1000;
    step();
    req0 = '0; req1 = '0;
    wait_idle();
    chk("dropped_req_rdy", 32'(at(order0, 0)), 32'd3);
    chk("dropped_req_rdy_lat3", 32'(at(order1, 0)), 32'd3);
    chk("dropped_req_data", 32'(data0), 32'(mem[13'h0AB]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
